// File: rtl/fp_preadder_pipe.sv
// Two-stage FP add pre-stage: unpack/classify/order (stage 1), align smaller mantissa with G/R/S (stage 2).
// Build option FP_PREADD_FTZ_EN: flush subnormal operands to signed zero before compare and alignment.
module fp_preadder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int XW = MAN_W + 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     number_A,
  input  logic [W-1:0]     number_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_of_great,
  output logic             sign_of_small,
  output logic             eff_sub,
  output logic [EXP_W-1:0] exp,
  output logic [XW-1:0]    mantis_great,
  output logic [XW-1:0]    mantis_small,
  output logic [1:0]       loss,
  output logic [W-1:0]     special_result,
  output logic             special_case
);

  typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_NAN} fp_class_e;

  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    fp_class_e c;
    if (e == '0)                 c = (f == '0) ? CL_ZERO : CL_SUB;
    else if (e == {EXP_W{1'b1}}) c = (f == '0) ? CL_INF : CL_NAN;
    else                         c = CL_NORM;
    return c;
  endfunction

  // handshake
  logic s1_v_q, s2_v_q, s2_free;

  assign s2_free  = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_free;

  // stage 1: unpack, classify, order, resolve specials
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  fp_class_e        cls_a, cls_b;
  logic             a_great;

  logic             s1_sign_g_d, s1_sign_s_d, s1_sc_d;
  logic [EXP_W-1:0] s1_exp_d, s1_dist_d;
  logic [MAN_W:0]   s1_man_g_d, s1_man_s_d;
  logic [W-1:0]     s1_sr_d;

  logic             s1_sign_g_q, s1_sign_s_q, s1_sc_q;
  logic [EXP_W-1:0] s1_exp_q, s1_dist_q;
  logic [MAN_W:0]   s1_man_g_q, s1_man_s_q;
  logic [W-1:0]     s1_sr_q;

  always_comb begin
    sign_a = number_A[W-1];
    sign_b = number_B[W-1];
    exp_a  = number_A[W-2 -: EXP_W];
    exp_b  = number_B[W-2 -: EXP_W];
    frac_a = number_A[MAN_W-1:0];
    frac_b = number_B[MAN_W-1:0];
    cls_a  = classify(exp_a, frac_a);
    cls_b  = classify(exp_b, frac_b);
`ifdef FP_PREADD_FTZ_EN
    if (cls_a == CL_SUB) begin
      frac_a = '0;
      cls_a  = CL_ZERO;
    end
    if (cls_b == CL_SUB) begin
      frac_b = '0;
      cls_b  = CL_ZERO;
    end
`endif
    // subnormals and zeros share the exponent of the smallest normal
    eff_a   = (exp_a == '0) ? EXP_ONE : exp_a;
    eff_b   = (exp_b == '0) ? EXP_ONE : exp_b;
    a_great = {exp_a, frac_a} >= {exp_b, frac_b};

    if (a_great) begin
      s1_sign_g_d = sign_a;
      s1_sign_s_d = sign_b;
      s1_exp_d    = eff_a;
      s1_dist_d   = eff_a - eff_b;
      s1_man_g_d  = {|exp_a, frac_a};
      s1_man_s_d  = {|exp_b, frac_b};
    end else begin
      s1_sign_g_d = sign_b;
      s1_sign_s_d = sign_a;
      s1_exp_d    = eff_b;
      s1_dist_d   = eff_b - eff_a;
      s1_man_g_d  = {|exp_b, frac_b};
      s1_man_s_d  = {|exp_a, frac_a};
    end

    s1_sc_d = 1'b0;
    s1_sr_d = '0;
    if (cls_a == CL_NAN || cls_b == CL_NAN) begin
      s1_sc_d = 1'b1;
      s1_sr_d = QNAN;
    end else if (cls_a == CL_INF && cls_b == CL_INF && sign_a != sign_b) begin
      s1_sc_d = 1'b1;
      s1_sr_d = QNAN;
    end else if (cls_a == CL_INF) begin
      s1_sc_d = 1'b1;
      s1_sr_d = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_b == CL_INF) begin
      s1_sc_d = 1'b1;
      s1_sr_d = {sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_sign_g_q <= 1'b0;
      s1_sign_s_q <= 1'b0;
      s1_sc_q     <= 1'b0;
      s1_exp_q    <= '0;
      s1_dist_q   <= '0;
      s1_man_g_q  <= '0;
      s1_man_s_q  <= '0;
      s1_sr_q     <= '0;
    end else begin
      if (in_ready) s1_v_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign_g_q <= s1_sign_g_d;
        s1_sign_s_q <= s1_sign_s_d;
        s1_sc_q     <= s1_sc_d;
        s1_exp_q    <= s1_exp_d;
        s1_dist_q   <= s1_dist_d;
        s1_man_g_q  <= s1_man_g_d;
        s1_man_s_q  <= s1_man_s_d;
        s1_sr_q     <= s1_sr_d;
      end
    end
  end

  // stage 2: align smaller mantissa, fold shifted-out bits into sticky
  logic [XW-1:0] ext_s, lost_mask, shifted;
  logic          sticky, far;
  logic [XW-1:0] ms_d;
  logic [1:0]    loss_d;

  always_comb begin
    ext_s     = {1'b0, s1_man_s_q, 3'b000};
    far       = int'(s1_dist_q) >= XW;
    lost_mask = ~({XW{1'b1}} << s1_dist_q);
    shifted   = ext_s >> s1_dist_q;
    sticky    = |(ext_s & lost_mask);
    if (far) begin
      ms_d   = {{(XW-1){1'b0}}, |ext_s};
      loss_d = {1'b1, |ext_s};
    end else begin
      ms_d   = shifted | {{(XW-1){1'b0}}, sticky};
      loss_d = {1'b0, sticky};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q         <= 1'b0;
      sign_of_great  <= 1'b0;
      sign_of_small  <= 1'b0;
      eff_sub        <= 1'b0;
      exp            <= '0;
      mantis_great   <= '0;
      mantis_small   <= '0;
      loss           <= '0;
      special_result <= '0;
      special_case   <= 1'b0;
    end else if (s2_free) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        sign_of_great  <= s1_sign_g_q;
        sign_of_small  <= s1_sign_s_q;
        eff_sub        <= s1_sign_g_q ^ s1_sign_s_q;
        exp            <= s1_exp_q;
        mantis_great   <= {1'b0, s1_man_g_q, 3'b000};
        mantis_small   <= ms_d;
        loss           <= loss_d;
        special_result <= s1_sr_q;
        special_case   <= s1_sc_q;
      end
    end
  end

  assign out_valid = s2_v_q;

endmodule

// File: tb/tb_fp_preadder_pipe.sv
// Self-checking bench for fp_preadder_pipe (EXP_W=8, MAN_W=23) against an arithmetic reference model.
module tb_fp_preadder_pipe;

  typedef struct packed {
    logic        sg;
    logic        ss;
    logic        es;
    logic [7:0]  ex;
    logic [27:0] mg;
    logic [27:0] ms;
    logic [1:0]  loss;
    logic [31:0] sr;
    logic        sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] number_A = '0;
  logic [31:0] number_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        o_sg, o_ss, o_es, o_sc;
  logic [7:0]  o_exp;
  logic [27:0] o_mg, o_ms;
  logic [1:0]  o_loss;
  logic [31:0] o_sr;
  exp_t        obs;

  int n_tests = 0;
  int n_fail  = 0;

  fp_preadder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .number_A(number_A), .number_B(number_B), .out_valid(out_valid), .out_ready(out_ready),
    .sign_of_great(o_sg), .sign_of_small(o_ss), .eff_sub(o_es), .exp(o_exp),
    .mantis_great(o_mg), .mantis_small(o_ms), .loss(o_loss),
    .special_result(o_sr), .special_case(o_sc)
  );

  assign obs = {o_sg, o_ss, o_es, o_exp, o_mg, o_ms, o_loss, o_sr, o_sc};

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: magnitude order by value, then integer alignment with sticky from the remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    bit     sa, sb, nan_a, nan_b, inf_a, inf_b, a_g;
    longint ea, eb, fa, fb, siga, sigb, eg, es, sg, ss, d, ext, rem, t;
    sa = a[31];
    sb = b[31];
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
`ifdef FP_PREADD_FTZ_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    nan_a = (ea == 255) && (fa != 0);
    nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0);
    inf_b = (eb == 255) && (fb == 0);
    siga  = fa + ((ea != 0) ? longint'(8388608) : longint'(0));
    sigb  = fb + ((eb != 0) ? longint'(8388608) : longint'(0));
    a_g   = (ea * 8388608 + fa) >= (eb * 8388608 + fb);
    r.sg  = a_g ? sa : sb;
    r.ss  = a_g ? sb : sa;
    r.es  = r.sg ^ r.ss;
    eg    = a_g ? ea : eb;
    es    = a_g ? eb : ea;
    sg    = a_g ? siga : sigb;
    ss    = a_g ? sigb : siga;
    if (eg == 0) eg = 1;
    if (es == 0) es = 1;
    r.ex  = 8'(eg);
    r.mg  = 28'(sg * 8);
    ext   = ss * 8;
    d     = eg - es;
    if (d >= 28) begin
      r.ms   = (ext != 0) ? 28'd1 : 28'd0;
      r.loss = (ext != 0) ? 2'b11 : 2'b10;
    end else begin
      rem    = ext % (longint'(1) << d);
      t      = (ext >> d) | ((rem != 0) ? longint'(1) : longint'(0));
      r.ms   = 28'(t);
      r.loss = (rem != 0) ? 2'b01 : 2'b00;
    end
    r.sc = 1'b1;
    r.sr = 32'h7FC00000;
    if (nan_a || nan_b) r.sr = 32'h7FC00000;
    else if (inf_a && inf_b && sa != sb) r.sr = 32'h7FC00000;
    else if (inf_a) r.sr = {sa, 8'hFF, 23'd0};
    else if (inf_b) r.sr = {sb, 8'hFF, 23'd0};
    else begin
      r.sc = 1'b0;
      r.sr = 32'd0;
    end
    return r;
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int          ea, eb;
    logic [22:0] fa, fb;
    logic [31:0] tmp;
    ea = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 254));
    if ($urandom_range(0, 9) == 0) ea = 255;
    case ($urandom_range(0, 7))
      0:       eb = 0;
      1:       eb = 255;
      2, 3:    eb = ea - int'($urandom_range(0, 4));
      4:       eb = ea;
      5:       eb = ea - int'($urandom_range(20, 40));
      default: eb = int'($urandom_range(1, 254));
    endcase
    if (eb < 0) eb = 0;
    fa = 23'($urandom);
    fb = 23'($urandom);
    if ($urandom_range(0, 5) == 0) fa = '0;
    if ($urandom_range(0, 5) == 0) fb = '0;
    if ($urandom_range(0, 7) == 0) fb = fa;
    a = {1'($urandom_range(0, 1)), 8'(ea), fa};
    b = {1'($urandom_range(0, 1)), 8'(eb), fb};
    if ($urandom_range(0, 1) == 1) begin
      tmp = a;
      a   = b;
      b   = tmp;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va[7] = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h00000001,
                           32'h41800000, 32'h7FC00001, 32'h3F800000};
    logic [31:0] vb[7] = '{32'h3F800000, 32'h30800000, 32'hFF800000, 32'h00000001,
                           32'h3F800001, 32'h3F800000, 32'hFF800000};
    exp_t got[7];
    exp_t e;
    bit   seen;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      number_A  = va[i];
      number_B  = vb[i];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0;
      got[i] = '0;
      for (int c = 0; c < 10 && !seen; c++) begin
        #1;
        if (out_valid === 1'b1) begin
          seen = 1'b1;
          got[i] = obs;
        end else begin
          @(negedge clk);
        end
      end
      e = model(va[i], vb[i]);
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL dir_timeout[%0d]: got no out_valid expected out_valid within 10 cycles", i);
      end else if (got[i] !== e) begin
        n_fail++;
        $display("FAIL dir_model[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    n_tests++;
    if ({got[0].ex, got[0].mg, got[0].ms, got[0].loss, got[0].es, got[0].sc} !==
        {8'h7F, 28'h4000000, 28'h4000000, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dir_equal_ones: got exp=%h mg=%h ms=%h loss=%b es=%b sc=%b expected 7f 4000000 4000000 00 0 0",
               got[0].ex, got[0].mg, got[0].ms, got[0].loss, got[0].es, got[0].sc);
    end
    n_tests++;
    if ({got[1].ms, got[1].loss} !== {28'h0000001, 2'b11}) begin
      n_fail++;
      $display("FAIL dir_flush: got ms=%h loss=%b expected 0000001 11", got[1].ms, got[1].loss);
    end
    n_tests++;
    if ({got[2].sc, got[2].sr} !== {1'b1, 32'h7FC00000}) begin
      n_fail++;
      $display("FAIL dir_inf_minus_inf: got sc=%b sr=%h expected 1 7fc00000", got[2].sc, got[2].sr);
    end
`ifdef FP_PREADD_FTZ_EN
    n_tests++;
    if ({got[3].mg, got[3].ms, got[3].ex} !== {28'h0, 28'h0, 8'h01}) begin
      n_fail++;
      $display("FAIL dir_subnormal_ftz: got mg=%h ms=%h exp=%h expected 0 0 01", got[3].mg, got[3].ms, got[3].ex);
    end
`else
    n_tests++;
    if ({got[3].ms, got[3].ex} !== {28'h0000008, 8'h01}) begin
      n_fail++;
      $display("FAIL dir_subnormal: got ms=%h exp=%h expected 0000008 01", got[3].ms, got[3].ex);
    end
`endif
    n_tests++;
    if ({got[4].ms, got[4].loss} !== {28'h0400001, 2'b01}) begin
      n_fail++;
      $display("FAIL dir_sticky: got ms=%h loss=%b expected 0400001 01", got[4].ms, got[4].loss);
    end
    n_tests++;
    if ({got[5].sc, got[5].sr} !== {1'b1, 32'h7FC00000}) begin
      n_fail++;
      $display("FAIL dir_nan: got sc=%b sr=%h expected 1 7fc00000", got[5].sc, got[5].sr);
    end
    n_tests++;
    if ({got[6].sc, got[6].sr} !== {1'b1, 32'hFF800000}) begin
      n_fail++;
      $display("FAIL dir_single_inf: got sc=%b sr=%h expected 1 ff800000", got[6].sc, got[6].sr);
    end
  endtask

  task automatic test_throughput();
    logic [31:0] pa[8], pb[8];
    exp_t        q[$];
    exp_t        e;
    int          sent = 0;
    for (int i = 0; i < 8; i++) gen_pair(pa[i], pb[i]);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        number_A = pa[sent];
        number_B = pb[sent];
      end
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL tput_in_ready[%0d]: got %b expected 1", cyc, in_ready);
      end
      n_tests++;
      if (out_valid !== (cyc >= 2 && cyc < 10)) begin
        n_fail++;
        $display("FAIL tput_out_valid[%0d]: got %b expected %b", cyc, out_valid, (cyc >= 2 && cyc < 10));
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL tput_data[%0d]: got %h expected %h", cyc, obs, e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(pa[sent], pb[sent]));
        sent++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[3], pb[3];
    exp_t        q[$];
    exp_t        e, held;
    int          sent = 0;
    int          got = 0;
    held = '0;
    for (int i = 0; i < 3; i++) gen_pair(pa[i], pb[i]);
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 3);
      if (sent < 3) begin
        number_A = pa[sent];
        number_B = pb[sent];
      end
      #1;
      n_tests++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected %b", cyc, in_ready, (q.size() < 2) || out_ready);
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_tests++;
        if ({in_ready, out_valid} !== 2'b01) begin
          n_fail++;
          $display("FAIL b2b_stall[%0d]: got in_ready=%b out_valid=%b expected 0 1", cyc, in_ready, out_valid);
        end
        if (cyc == 2) held = obs;
        else begin
          n_tests++;
          if (obs !== held) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: got %h expected %h", cyc, obs, held);
          end
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious[%0d]: got out_valid=1 expected no pending pair", cyc);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: got %h expected %h", cyc, obs, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(pa[sent], pb[sent]));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs expected 3", got);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [31:0] ca, cb;
    bit          have = 1'b0;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    localparam int N = 400;
    while ((sent < N || got < sent) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < N) begin
        gen_pair(ca, cb);
        have = 1'b1;
      end
      number_A  = ca;
      number_B  = cb;
      in_valid  = have && ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, in_ready, (q.size() < 2) || out_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious[%0d]: got out_valid=1 expected no pending pair", cyc);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL rand_data[%0d]: got %h expected %h", cyc, obs, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(ca, cb));
        sent++;
        have = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (sent != N || got != N) begin
      n_fail++;
      $display("FAIL rand_count: got sent=%0d received=%0d expected %0d each", sent, got, N);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      gen_pair(a, b);
      number_A = a;
      number_B = b;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_full: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_flags: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h expected 0", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_output[%0d]: got %b expected 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_throughput();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
